// File: rtl/riscv_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// State encoding, port identifiers and data width.
package riscv_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

endpackage

// File: rtl/riscv_arb_pick.sv
// Combinational winner selection between fetch and data ports.
// On a tie the port not granted most recently wins.
module riscv_arb_pick
    import riscv_arb_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  port_t last_gnt,
    output port_t winner
);

    always_comb begin
        winner = PORT_I;
        priority case (1'b1)
            i_req && d_req: winner = (last_gnt == PORT_D) ? PORT_I : PORT_D;
            d_req:          winner = PORT_D;
            default:        winner = PORT_I;
        endcase
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter onto a single-port memory, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-first.
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;
    logic            rst_q;
    logic            blank;
    logic            to_hit;
    logic [XLEN-1:0] rsp_data;
    port_t           last_gnt, winner;

    // Outputs stay quiet while in reset and for one cycle after it.
    assign blank  = reset | rst_q;
    assign to_hit = (cnt == TO_LAST);
    assign rsp_data = mem_rvalid ? mem_rdata : '0;

    riscv_arb_pick u_pick (
        .i_req    (i_req),
        .d_req    (d_req),
        .last_gnt (last_gnt),
        .winner   (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rst_q <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rst_q <= 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_gnt <= PORT_I;
        else if (i_gnt || d_gnt)
            last_gnt <= winner;
    end
`else
    assign last_gnt = PORT_I;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        err       = 1'b0;
        if (!blank) begin
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        mem_req = 1'b1;
                        if (winner == PORT_D) begin
                            mem_we    = d_we;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                        end else begin
                            mem_addr  = i_addr;
                        end
                        if (mem_ready) begin
                            cnt_nx = '0;
                            if (winner == PORT_D) begin
                                d_gnt    = 1'b1;
                                state_nx = WAIT_D;
                            end else begin
                                i_gnt    = 1'b1;
                                state_nx = WAIT_I;
                            end
                        end
                    end
                end
                WAIT_I, WAIT_D: begin
                    // A real response beats a timeout landing in the same cycle.
                    if (mem_rvalid || to_hit) begin
                        err      = !mem_rvalid;
                        state_nx = IDLE;
                        if (state == WAIT_I) begin
                            i_rvalid = 1'b1;
                            i_rdata  = rsp_data;
                        end else begin
                            d_rvalid = 1'b1;
                            d_rdata  = rsp_data;
                        end
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: transaction-level model
// predicts grants and responses; a negedge monitor checks them.
module tb_riscv_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    riscv_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_req_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } gnt_exp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } rsp_exp_t;

    gnt_exp_t    gq[$];
    rsp_exp_t    rq[$];
    port_req_t   pi, pd;
    bit          last_d;
    bit          exp_zero, exp_mreq, late_rv, arrive_en, rd_fix;
    logic [31:0] rd_pat;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    // Reference arbitration: single requester always wins; ties by policy.
    function automatic bit pick_d();
        if (pi.req && pd.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !last_d;
`else
            return 1'b1;
`endif
        end
        return pd.req;
    endfunction

    function automatic port_req_t new_i();
        port_req_t p;
        p.req = 1'b1; p.we = 1'b0;
        p.addr = $urandom; p.wdata = '0;
        return p;
    endfunction

    function automatic port_req_t new_d();
        port_req_t p;
        p.req = 1'b1; p.we = 1'($urandom_range(0, 1));
        p.addr = $urandom; p.wdata = $urandom;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        exp_zero = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic drive_reqs();
        i_req = pi.req; i_addr = pi.addr;
        d_req = pd.req; d_we = pd.we;
        d_addr = pd.addr; d_wdata = pd.wdata;
    endtask

    task automatic do_reset(input int n);
        for (int j = 0; j <= n; j++) begin
            step();
            reset      = (j < n);
            exp_zero   = 1'b1;
            i_req      = 1'($urandom_range(0, 1));
            d_req      = 1'($urandom_range(0, 1));
            mem_ready  = 1'b1;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
        end
        last_d = 1'b0;
    endtask

    task automatic run_txn(input int stall_sel, input int k_sel,
                           input int to_sel, input int abort_w);
        bit       wd, tmo, aborted;
        int       s, k;
        gnt_exp_t g;
        rsp_exp_t r;
        aborted = 1'b0;
        if (!pi.req && !pd.req) begin
            if ($urandom_range(0, 1) == 1) pi = new_i();
            else pd = new_d();
        end
        wd = pick_d();
        s  = (stall_sel >= 0) ? stall_sel : $urandom_range(0, 2);
        for (int j = 0; j <= s; j++) begin
            step();
            drive_reqs();
            mem_ready  = (j == s);
            mem_rvalid = (j == 0) ? late_rv : ($urandom_range(0, 5) == 0);
            mem_rdata  = $urandom;
            late_rv    = 1'b0;
            exp_mreq   = 1'b1;
        end
        g.is_d  = wd;
        g.we    = wd ? pd.we : 1'b0;
        g.addr  = wd ? pd.addr : pi.addr;
        g.wdata = wd ? pd.wdata : 32'h0;
        g.cyc   = cyc;
        gq.push_back(g);
        if (wd) pd.req = 1'b0;
        else pi.req = 1'b0;
        last_d = wd;
        tmo = (to_sel >= 0) ? (to_sel != 0) : ($urandom_range(0, 5) == 0);
        if (tmo) k = TO - 1;
        else if (k_sel >= 0) k = k_sel;
        else if ($urandom_range(0, 3) == 0) k = $urandom_range(0, TO - 1);
        else k = $urandom_range(0, 3);
        for (int w = 0; w <= k && !aborted; w++) begin
            step();
            if (arrive_en && !pi.req && $urandom_range(0, 2) == 0) pi = new_i();
            if (arrive_en && !pd.req && $urandom_range(0, 2) == 0) pd = new_d();
            drive_reqs();
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rdata  = rd_fix ? rd_pat : $urandom;
            mem_rvalid = !tmo && (w == k);
            exp_mreq   = 1'b0;
            if (w == abort_w) begin
                reset      = 1'b1;
                exp_zero   = 1'b1;
                mem_rvalid = 1'b1;
                aborted    = 1'b1;
            end else if (w == k) begin
                r.is_d = wd;
                r.data = tmo ? 32'h0 : mem_rdata;
                r.err  = tmo;
                r.cyc  = cyc;
                rq.push_back(r);
            end
        end
        if (aborted) begin
            step();
            exp_zero   = 1'b1;
            mem_ready  = 1'b1;
            mem_rvalid = 1'b1;
            last_d     = 1'b0;
        end else begin
            late_rv = tmo && ($urandom_range(0, 1) == 1);
        end
    endtask

    always @(negedge clk) begin
        if (exp_zero) begin
            chk("reset_quiet",
                32'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                      mem_req, mem_we, mem_addr, mem_wdata, err}), 32'h0);
        end else begin
            gnt_exp_t g;
            rsp_exp_t r;
            chk("mem_req", 32'(mem_req), 32'(exp_mreq));
            chk("dual_gnt", 32'(i_gnt & d_gnt), 32'h0);
            if (i_gnt || d_gnt) begin
                if (gq.size() == 0) begin
                    chk("spurious_gnt", 32'(1), 32'(0));
                end else begin
                    g = gq.pop_front();
                    chk("gnt_port", 32'(d_gnt), 32'(g.is_d));
                    chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                    chk("mem_addr", mem_addr, g.addr);
                    chk("mem_we", 32'(mem_we), 32'(g.we));
                    chk("mem_wdata", mem_wdata, g.wdata);
                end
            end
            if (i_rvalid || d_rvalid) begin
                if (rq.size() == 0) begin
                    chk("spurious_rvalid", 32'(1), 32'(0));
                end else begin
                    r = rq.pop_front();
                    chk("rsp_port", 32'(d_rvalid), 32'(r.is_d));
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rsp_data", d_rvalid ? d_rdata : i_rdata, r.data);
                    chk("rsp_err", 32'(err), 32'(r.err));
                end
            end else begin
                chk("err_idle", 32'(err), 32'h0);
            end
            if (!i_rvalid) chk("i_rdata_idle", i_rdata, 32'h0);
            if (!d_rvalid) chk("d_rdata_idle", d_rdata, 32'h0);
        end
    end

    initial begin
        reset = 1'b1; exp_zero = 1'b1; exp_mreq = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        pi = '{1'b0, 1'b0, 32'h0, 32'h0};
        pd = '{1'b0, 1'b0, 32'h0, 32'h0};
        last_d = 1'b0; late_rv = 1'b0; arrive_en = 1'b0;
        rd_fix = 1'b0; rd_pat = 32'hDEADBEEF;

        do_reset(2);

        pi = '{1'b1, 1'b0, 32'h10, 32'h0};
        rd_fix = 1'b1;
        run_txn(0, 2, 0, -1);
        rd_fix = 1'b0;

        pd = '{1'b1, 1'b1, 32'h100, 32'h55};
        run_txn(0, 1, 0, -1);

        for (int t = 0; t < 4; t++) begin
            if (!pi.req) pi = new_i();
            if (!pd.req) pd = new_d();
            run_txn(-1, -1, 0, -1);
        end

        if (!pd.req) begin
            pd = new_d();
            pd.we = 1'b0;
        end
        run_txn(0, -1, 1, -1);
        late_rv = 1'b1;

        while (pd.req) run_txn(-1, -1, 0, -1);
        if (!pi.req) pi = new_i();
        run_txn(5, 0, 0, -1);

        while (pi.req || pd.req) run_txn(-1, -1, 0, -1);
        pd = new_d();
        pd.we = 1'b0;
        run_txn(0, 10, 0, 3);
        pi = new_i();
        run_txn(-1, 1, 0, -1);

        arrive_en = 1'b1;
        for (int t = 0; t < 300; t++) run_txn(-1, -1, -1, -1);

        arrive_en = 1'b0;
        step();
        pi.req = 1'b0; pd.req = 1'b0;
        drive_reqs();
        mem_rvalid = 1'b0; exp_mreq = 1'b0;
        step();
        step();
        chk("drain_gnt", 32'(gq.size()), 32'h0);
        chk("drain_rsp", 32'(rq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles before a response is forced; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req, i_addr[31:0]  input  1/32  instruction-fetch request (read only).
REQ-005 i_gnt, i_rvalid, i_rdata[31:0]  output  1/1/32  fetch accept pulse, response pulse, response data.
REQ-006 d_req, d_we, d_addr[31:0], d_wdata[31:0]  input  1/1/32/32  data-port request.
REQ-007 d_gnt, d_rvalid, d_rdata[31:0]  output  1/1/32  data accept pulse, response pulse, response data.
REQ-008 mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0]  output  1/1/32/32  unified single-port memory request.
REQ-009 mem_ready, mem_rvalid, mem_rdata[31:0]  input  1/1/32  memory accept, response (read data or write ack), data.
REQ-010 err  output  1  one-cycle pulse on timeout.

Function
REQ-011 FSM states: IDLE, WAIT_I, WAIT_D; at most one transaction outstanding.
REQ-012 IDLE: if any req is high, the winner's addr/we/wdata drive mem_* combinationally with mem_req=1; i-port winner forces mem_we=0 and mem_wdata=0.
REQ-013 IDLE with mem_req=1 and mem_ready=1: the winner's gnt pulses high in that same cycle; next state WAIT_I or WAIT_D.
REQ-014 IDLE with mem_ready=0: no gnt, state unchanged, and arbitration is re-evaluated next cycle.
REQ-015 Requesters hold req, addr, we, and wdata stable until gnt; the arbiter does not register request fields.
REQ-016 WAIT_x: mem_req=0 and both gnt=0; on mem_rvalid=1, x_rvalid=1 and x_rdata=mem_rdata for exactly one cycle, then IDLE.
REQ-017 The non-owner's rvalid stays 0 and its rdata stays 0 at all times.
REQ-018 A wait counter clears on entry to WAIT_x and increments each WAIT cycle without mem_rvalid.
REQ-019 When the counter reaches TIMEOUT-1 without mem_rvalid: x_rvalid=1, x_rdata=0, err=1 for one cycle, then IDLE.
REQ-020 mem_rvalid and timeout in the same cycle: mem_rvalid wins, err=0, and data is forwarded.
REQ-021 mem_rvalid while in IDLE is ignored; a late response after a timeout is discarded.
REQ-022 Throughput: at most one grant per two cycles; a new grant is possible in the cycle after the response cycle.

Reset
REQ-023 Reset puts the FSM in IDLE, clears the wait counter, and points the round-robin pointer to favour D.
REQ-024 During reset and in the cycle after, all outputs are 0: gnt, rvalid, rdata, mem_req, mem_we, mem_addr, mem_wdata, err.
REQ-025 Reset mid-WAIT abandons the transaction; no rvalid is issued for it.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined, simultaneous i_req and d_req grant the port not granted most recently.
REQ-027 With ARB_ROUND_ROBIN_EN defined, the last-grant pointer updates only on an accepted grant.
REQ-028 Without ARB_ROUND_ROBIN_EN, d_req has fixed priority over i_req, and no pointer flop exists.
REQ-029 A single pending requester is always granted, independent of the macro.

Structure
REQ-030 Package riscv_arb_pkg holds the state enum (IDLE, WAIT_I, WAIT_D) and the port-ID typedef (PORT_I, PORT_D).
REQ-031 Package riscv_arb_pkg holds the XLEN=32 constant.
REQ-032 One sub-module, riscv_arb_pick, is combinational winner selection; inputs i_req, d_req, last-grant; output winner ID.
REQ-033 The FSM, counter, and response steering reside in riscv_mem_arbiter.

Verification
REQ-034 Fetch-only read: i_req=1, i_addr=0x10, mem_ready=1; after 3 cycles mem_rvalid with 0xDEADBEEF gives i_gnt in cycle 0 and i_rvalid with i_rdata=0xDEADBEEF in cycle 3; d_rvalid stays 0.
REQ-035 Contention, macro on: i_req and d_req held high for 4 transactions; grants go D, I, D, I. Macro off: D, D, D, D with I starved.
REQ-036 Data store: d_we=1, d_addr=0x100, d_wdata=0x55; gives mem_we=1, mem_addr=0x100, mem_wdata=0x55, d_gnt, then d_rvalid on ack.
REQ-037 Timeout, TIMEOUT=16: after a read is granted, mem_rvalid is withheld; in WAIT cycle 15, x_rvalid=1, x_rdata=0, err=1, then IDLE; a later mem_rvalid is ignored.
REQ-038 mem_ready=0 for 5 cycles with i_req=1: mem_req=1 throughout and no i_gnt; i_gnt on the first mem_ready=1.
REQ-039 Reset asserted in WAIT_D: state returns to IDLE, no d_rvalid, all outputs 0; a fresh fetch then completes normally.
